// File: rtl/key_pkg.sv
// Shared definitions for key conditioning: FSM states and default 50 MHz timing.
package key_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPressDeb,
    StHeld,
    StRepeat,
    StRelDeb
  } key_state_e;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEBOUNCE_MS      = 10;
  localparam int unsigned REPEAT_DELAY_MS  = 500;
  localparam int unsigned REPEAT_PERIOD_MS = 100;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned DEF_REPEAT_DELAY    = (CLK_HZ / 1000) * REPEAT_DELAY_MS;
  localparam int unsigned DEF_REPEAT_PERIOD   = (CLK_HZ / 1000) * REPEAT_PERIOD_MS;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs, with a selectable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff1 <= RESET_VAL;
      r_ff2 <= RESET_VAL;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/key_step_gen.sv
// Debounces an active-low push-button and emits single-cycle step pulses,
// with optional auto-repeat while the key is held.
module key_step_gen
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic repeat_en,
  output logic step,
  output logic step_n,
  output logic key_level
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DlyLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PerLast = CNT_W'(REPEAT_PERIOD - 1);

  logic             w_key_n_sync;
  logic             w_s;
  key_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_rep, w_rep_d;
  logic             r_step, w_step_d;
  logic             r_step_n;
  logic             r_key_level, w_level_d;

  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .i_d (key_n),
    .o_q (w_key_n_sync)
  );

  assign w_s = ~w_key_n_sync;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 1'b1;
    w_rep_d   = r_rep;
    w_step_d  = 1'b0;
    w_level_d = r_key_level;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_s) w_state_d = StPressDeb;
      end
      StPressDeb: begin
        if (!w_s) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_d = StHeld;
          w_cnt_d   = '0;
          w_step_d  = 1'b1;
          w_level_d = 1'b1;
          w_rep_d   = 1'b0;
        end
      end
      StHeld: begin
        if (!w_s) begin
          w_state_d = StRelDeb;
          w_cnt_d   = '0;
        end else if (!repeat_en) begin
          // Parked at zero so the delay restarts cleanly when repeat is enabled.
          w_cnt_d = '0;
        end else if (r_cnt == DlyLast) begin
          w_state_d = StRepeat;
          w_cnt_d   = '0;
          w_step_d  = 1'b1;
          w_rep_d   = 1'b1;
        end
      end
      StRepeat: begin
        if (!w_s) begin
          w_state_d = StRelDeb;
          w_cnt_d   = '0;
        end else if (!repeat_en) begin
          w_state_d = StHeld;
          w_cnt_d   = '0;
        end else if (r_cnt == PerLast) begin
          w_cnt_d  = '0;
          w_step_d = 1'b1;
        end
      end
      StRelDeb: begin
        if (w_s) begin
          // Release bounce: resume where we were, without a step.
          w_state_d = r_rep ? StRepeat : StHeld;
          w_cnt_d   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_level_d = 1'b0;
          w_rep_d   = 1'b0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rep       <= 1'b0;
      r_step      <= 1'b0;
      r_step_n    <= 1'b1;
      r_key_level <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rep       <= w_rep_d;
      r_step      <= w_step_d;
      r_step_n    <= ~w_step_d;
      r_key_level <= w_level_d;
    end
  end

  assign step      = r_step;
  assign step_n    = r_step_n;
  assign key_level = r_key_level;

endmodule
